// File: rtl/bank_ctrl_sequencer.sv
// bank_ctrl_sequencer: timed strobe sequencer for one 256x256 eDRAM bank, with periodic refresh and idle sleep.
// Define BANK_CTRL_OPENPAGE_EN for the open-page policy; the default build is closed-page.
module bank_ctrl_sequencer #(
    parameter int T_PRE        = 2,
    parameter int T_RCD        = 2,
    parameter int T_SENSE      = 2,
    parameter int T_WR         = 2,
    parameter int T_WAKE       = 2,
    parameter int REF_INTERVAL = 1024,
    parameter int IDLE_GATE    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [10:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [10:0] bank_addr,
    output logic [31:0] din,
    output logic        precharge_en,
    output logic        row_decode_en,
    output logic        col_decode_en,
    output logic        sense_amp_en,
    output logic        write_driver_en,
    output logic        power_gate_en,
    output logic        rbb_en,
    input  logic [31:0] bank_dout,
    output logic        refresh_overrun
);
    typedef enum logic [3:0] {IDLE, PRE, ACT, RD, WR, REF_PRE, REF_ACT, REF_RST, SLEEP, WAKE} state_t;
    localparam int RW = $clog2(REF_INTERVAL + 1);
    localparam int IW = $clog2(IDLE_GATE + 1);

    state_t        state, state_nx;
    logic [7:0]    cnt, cnt_load;
    logic [RW-1:0] ref_cnt;
    logic [IW-1:0] idle_cnt;
    logic [7:0]    ref_row;
    logic [10:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          we_q, refresh_pending, done, ref_wrap, ref_done, op_done, accept, idle_go;
    logic          hit, open_vld, closing;

    assign done     = cnt == 8'd0;
    assign ref_wrap = ref_cnt == RW'(REF_INTERVAL - 1);
    assign ref_done = state == REF_RST && done;
    assign op_done  = (state == RD || state == WR) && done;
    assign accept   = req_valid && req_ready;
    assign idle_go  = state == IDLE && !req_valid && !refresh_pending && idle_cnt == IW'(IDLE_GATE - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= state_nx != state ? cnt_load : cnt - 8'd1;
        end
    end

    // Refresh outranks a waiting request; a hit on the open row skips PRE/ACT.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = refresh_pending ? REF_PRE :
                                req_valid ? (hit ? (req_we ? WR : RD) : PRE) :
                                idle_go ? (open_vld ? PRE : SLEEP) : IDLE;
            PRE:     state_nx = !done ? PRE : closing ? SLEEP : ACT;
            ACT:     state_nx = !done ? ACT : we_q ? WR : RD;
            RD:      state_nx = done ? IDLE : RD;
            WR:      state_nx = done ? IDLE : WR;
            REF_PRE: state_nx = done ? REF_ACT : REF_PRE;
            REF_ACT: state_nx = done ? REF_RST : REF_ACT;
            REF_RST: state_nx = done ? IDLE : REF_RST;
            SLEEP:   state_nx = (req_valid || refresh_pending) ? WAKE : SLEEP;
            WAKE:    state_nx = done ? IDLE : WAKE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_load = 8'd0;
        case (state_nx)
            PRE, REF_PRE: cnt_load = 8'(T_PRE - 1);
            ACT, REF_ACT: cnt_load = 8'(T_RCD - 1);
            RD, REF_RST:  cnt_load = 8'(T_SENSE - 1);
            WR:           cnt_load = 8'(T_WR - 1);
            WAKE:         cnt_load = 8'(T_WAKE - 1);
            default:      cnt_load = 8'd0;
        endcase
    end

    always_comb begin
        req_ready       = state == IDLE && !refresh_pending;
        precharge_en    = state == PRE || state == REF_PRE;
        row_decode_en   = state inside {ACT, RD, WR, REF_ACT, REF_RST} || (state == IDLE && open_vld);
        col_decode_en   = state == RD || state == WR;
        sense_amp_en    = state == RD || state == REF_RST;
        write_driver_en = state == WR;
        power_gate_en   = state == SLEEP;
        rbb_en          = state == SLEEP;
        bank_addr       = state inside {REF_PRE, REF_ACT, REF_RST} ? {ref_row, 3'b000} : addr_q;
        din             = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_cnt         <= '0;
            idle_cnt        <= '0;
            ref_row         <= '0;
            refresh_pending <= 1'b0;
            refresh_overrun <= 1'b0;
            addr_q          <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
        end else begin
            ref_cnt         <= ref_wrap ? '0 : ref_cnt + 1'b1;
            refresh_pending <= ref_wrap || (refresh_pending && !ref_done);
            refresh_overrun <= refresh_overrun || (ref_wrap && refresh_pending);
            idle_cnt        <= (state == IDLE && !req_valid && !refresh_pending) ? idle_cnt + 1'b1 : '0;
            ref_row         <= ref_done ? ref_row + 8'd1 : ref_row;
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
            end
            rsp_valid <= op_done;
            rsp_rdata <= (op_done && state == RD) ? bank_dout : '0;
        end
    end

`ifdef BANK_CTRL_OPENPAGE_EN
    logic [7:0] open_row;
    assign hit = open_vld && req_addr[10:3] == open_row;
    // Any precharge leaving IDLE closes the page; closing marks a PRE that heads into SLEEP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            open_vld <= 1'b0;
            open_row <= '0;
            closing  <= 1'b0;
        end else begin
            if (op_done) begin
                open_vld <= 1'b1;
                open_row <= addr_q[10:3];
            end else if (state == IDLE && (state_nx == PRE || state_nx == REF_PRE)) begin
                open_vld <= 1'b0;
            end
            if (state == IDLE) closing <= idle_go;
        end
    end
`else
    assign hit      = 1'b0;
    assign open_vld = 1'b0;
    assign closing  = 1'b0;
`endif
endmodule

// File: tb/tb_bank_ctrl_sequencer.sv
// tb_bank_ctrl_sequencer: scoreboard bench for bank_ctrl_sequencer (closed-page build).
module tb_bank_ctrl_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [10:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] bank_val = '0;
    logic        req_ready, rsp_valid, precharge_en, row_decode_en, col_decode_en, sense_amp_en;
    logic        write_driver_en, power_gate_en, rbb_en, refresh_overrun;
    logic [31:0] rsp_rdata, din, bank_dout;
    logic [10:0] bank_addr;
    logic [4:0]  stb;
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    logic        ov_rst_n = 1'b0;
    logic        ov_valid = 1'b0;
    logic        ov_ready, ov_rsp_valid, ov_pre, ov_row, ov_col, ov_sense, ov_wr, ov_gate, ov_rbb, ov_overrun;
    logic [31:0] ov_rdata, ov_din;
    logic [10:0] ov_addr;

    always #5 clk = ~clk;
    assign bank_dout = sense_amp_en ? bank_val : 32'h0;
    assign stb = {precharge_en, row_decode_en, col_decode_en, sense_amp_en, write_driver_en};

    bank_ctrl_sequencer #(.REF_INTERVAL(128)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bank_addr(bank_addr), .din(din), .precharge_en(precharge_en), .row_decode_en(row_decode_en),
        .col_decode_en(col_decode_en), .sense_amp_en(sense_amp_en), .write_driver_en(write_driver_en),
        .power_gate_en(power_gate_en), .rbb_en(rbb_en), .bank_dout(bank_dout),
        .refresh_overrun(refresh_overrun)
    );

    bank_ctrl_sequencer #(.REF_INTERVAL(4)) dut_ov (
        .clk(clk), .rst_n(ov_rst_n), .req_valid(ov_valid), .req_ready(ov_ready), .req_we(1'b0),
        .req_addr(11'h0A8), .req_wdata(32'h0), .rsp_valid(ov_rsp_valid), .rsp_rdata(ov_rdata),
        .bank_addr(ov_addr), .din(ov_din), .precharge_en(ov_pre), .row_decode_en(ov_row),
        .col_decode_en(ov_col), .sense_amp_en(ov_sense), .write_driver_en(ov_wr),
        .power_gate_en(ov_gate), .rbb_en(ov_rbb), .bank_dout(32'h0), .refresh_overrun(ov_overrun)
    );

    // Strobe safety invariants are watched on every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((precharge_en && |stb[3:0]) || (sense_amp_en && write_driver_en)) begin
                errors++;
                $display("FAIL strobe_invariant strobes=%b (precharge must be alone, sense and write exclusive)", stb);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string name, input logic we, input logic [10:0] addr, input logic [31:0] data);
        int n = 0;
        logic [4:0] e;
        logic [31:0] exp;
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_wdata = data;
        bank_val = we ? 32'h5555_AAAA : data;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL %s_accept req_ready=%b required 1 within 100 cycles", name, req_ready);
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        exp_q.push_back(we ? 32'h0 : data);
        for (int i = 0; i < 6; i++) begin
            e = i < 2 ? 5'b10000 : i < 4 ? 5'b01000 : we ? 5'b01101 : 5'b01110;
            checks++;
            if (stb !== e || rsp_valid !== 1'b0 || bank_addr !== addr || (we && din !== data)) begin
                errors++;
                $display("FAIL %s_seq[%0d] strobes=%b rsp=%b addr=%h din=%h required strobes=%b rsp=0 addr=%h din=%h",
                         name, i, stb, rsp_valid, bank_addr, din, e, addr, data);
            end
            tick();
        end
        checks++;
        if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_rsp rsp_valid=%b required 1 at accept+7", name, rsp_valid);
        end else begin
            exp = exp_q.pop_front();
            if (rsp_rdata !== exp || stb !== 5'b00000) begin
                errors++;
                $display("FAIL %s_rdata rdata=%h strobes=%b required rdata=%h strobes=00000", name, rsp_rdata, stb, exp);
            end
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_rsp_pulse rsp_valid=%b required 0 one cycle after completion", name, rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({stb, rsp_valid, rsp_rdata, bank_addr, din, power_gate_en, rbb_en, refresh_overrun} !== '0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state strobes=%b rsp=%b addr=%h din=%h gate=%b ready=%b required all 0 and ready=1",
                     stb, rsp_valid, bank_addr, din, power_gate_en, req_ready);
        end
        rst_n = 1'b1;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 11'h055;
        req_wdata = 32'hCAFE_F00D;
        bank_val = 32'h1357_9BDF;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (stb !== 5'b01110) begin
            errors++;
            $display("FAIL reset_setup strobes=%b required 01110 (in RD)", stb);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({stb, rsp_valid, rsp_rdata, bank_addr, din, power_gate_en, rbb_en, refresh_overrun} !== '0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_rd strobes=%b rsp=%b addr=%h din=%h ready=%b required all 0 and ready=1",
                     stb, rsp_valid, bank_addr, din, req_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_dropped[%0d] rsp=%b ready=%b required rsp=0 ready=1", i, rsp_valid, req_ready);
            end
            tick();
        end
    endtask

    task automatic test_read();
        do_op("read_123", 1'b0, 11'h123, 32'hDEAD_BEEF);
        do_op("read_2a0", 1'b0, 11'h2A0, 32'h0BAD_F00D);
    endtask

    task automatic test_write();
        do_op("write_7ff", 1'b1, 11'h7FF, 32'hA5A5_A5A5);
        do_op("write_000", 1'b1, 11'h000, 32'hFFFF_FFFF);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            do_op("b2b", 1'($urandom_range(0, 1)), 11'($urandom), $urandom);
    endtask

    task automatic test_page();
        do_op("page_a", 1'b0, {8'd5, 3'd1}, 32'h0000_0505);
        do_op("page_b", 1'b0, {8'd5, 3'd6}, 32'h0505_0000);
    endtask

    task automatic test_sleep();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (63) tick();
        checks++;
        if (power_gate_en !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL sleep_early gate=%b ready=%b required gate=0 ready=1 after 63 idle cycles", power_gate_en, req_ready);
        end
        tick();
        checks++;
        if (power_gate_en !== 1'b1 || rbb_en !== 1'b1 || stb !== 5'b00000 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL sleep_entry gate=%b rbb=%b strobes=%b ready=%b required 1 1 00000 0",
                     power_gate_en, rbb_en, stb, req_ready);
        end
        repeat (5) tick();
        checks++;
        if (power_gate_en !== 1'b1 || rbb_en !== 1'b1) begin
            errors++;
            $display("FAIL sleep_hold gate=%b rbb=%b required 1 1", power_gate_en, rbb_en);
        end
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 11'h4C2;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (power_gate_en !== 1'b0 || rbb_en !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL wake[%0d] gate=%b rbb=%b ready=%b required 0 0 0", i, power_gate_en, rbb_en, req_ready);
            end
        end
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wake_done ready=%b required 1 after 2 wake cycles", req_ready);
        end
        do_op("wake_read", 1'b0, 11'h4C2, 32'h600D_CAFE);
    endtask

    task automatic test_refresh();
        int n = 0;
        int refs = 0;
        int rsps = 0;
        logic acc;
        logic in_ref = 1'b0;
        logic [31:0] exp;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 11'h3C1;
        req_wdata = 32'h1111_2222;
        while (refs == 0 && n < 400) begin
            acc = req_ready && req_valid;
            tick();
            n++;
            if (acc) exp_q.push_back(32'h0);
            if (rsp_valid) begin
                rsps++;
                checks++;
                exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'hXXXX_XXXX;
                if (rsp_rdata !== exp) begin
                    errors++;
                    $display("FAIL ref_write_rsp rdata=%h required %h", rsp_rdata, exp);
                end
            end
            if (stb == 5'b01010 && !in_ref) begin
                refs++;
                req_valid = 1'b0;
                checks++;
                if (exp_q.size() != 0 || rsps == 0 || bank_addr !== 11'h000 || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ref_order inflight=%0d rsps=%0d addr=%h ready=%b required 0 >0 000 0",
                             exp_q.size(), rsps, bank_addr, req_ready);
                end
            end
            in_ref = stb == 5'b01010;
        end
        req_valid = 1'b0;
        checks++;
        if (refs == 0) begin
            errors++;
            $display("FAIL ref_timeout refreshes=%0d required 1 within 400 cycles", refs);
            return;
        end
        n = 0;
        while (refs < 257 && n < 40000) begin
            tick();
            n++;
            if (stb == 5'b01010 && !in_ref) begin
                refs++;
                checks++;
                if (bank_addr !== {8'(refs - 1), 3'b000} || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ref_row[%0d] addr=%h ready=%b required addr=%h ready=0",
                             refs, bank_addr, req_ready, {8'(refs - 1), 3'b000});
                end
            end
            in_ref = stb == 5'b01010;
        end
        checks++;
        if (refs < 257) begin
            errors++;
            $display("FAIL ref_row_wrap refreshes=%0d required 257", refs);
        end
    endtask

    task automatic test_overrun();
        int n = 0;
        int rsps = 0;
        logic stuck = 1'b1;
        ov_rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (ov_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_reset overrun=%b required 0", ov_overrun);
        end
        ov_rst_n = 1'b1;
        ov_valid = 1'b1;
        while (!ov_overrun && n < 500) begin
            tick();
            n++;
            if (ov_rsp_valid) rsps++;
        end
        checks++;
        if (ov_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set overrun=%b required 1 within 500 cycles", ov_overrun);
        end
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ov_rsp_valid) rsps++;
            if (ov_overrun !== 1'b1) stuck = 1'b0;
        end
        checks++;
        if (!stuck || rsps == 0) begin
            errors++;
            $display("FAIL overrun_sticky held=%b reads=%0d required held=1 reads>0", stuck, rsps);
        end
        ov_valid = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_page();
        test_sleep();
        test_refresh();
        test_overrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end
endmodule
